input_conditioner: RTL and testbench

Upstream stage of the player state machine. Takes the three raw, asynchronous push-button levels, synchronises and debounces each one, and resolves left/right conflicts. It turns shoot presses into edge-triggered requests that are never dropped. Once per frame it presents one player command to the player state machine over a valid/ready handshake.

---
 rtl/game_pkg.sv | 30 +++
 rtl/debouncer.sv | 45 ++++
 rtl/input_conditioner.sv | 101 ++++++++++
 tb/tb_input_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and timing constants for the game's player input path.
package game_pkg;

  localparam int CLK_FREQ_HZ = 25_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  typedef struct packed {
    logic left;
    logic right;
    logic shoot;
  } player_cmd_t;

  typedef enum logic [1:0] {
    BTN_LEFT  = 2'd0,
    BTN_RIGHT = 2'd1,
    BTN_SHOOT = 2'd2
  } btn_id_e;

  // Opposing directions cancel so the player never receives both at once.
  function automatic player_cmd_t resolve_cmd(input logic left, input logic right,
                                              input logic shoot);
    player_cmd_t cmd;
    cmd.left  = left & ~right;
    cmd.right = right & ~left;
    cmd.shoot = shoot;
    return cmd;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
module debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync_s;
  logic [CNT_W-1:0] cnt_q;

  assign sync_s = sync_q[1];

  // The stable level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync_q   <= 2'b00;
      cnt_q    <= '0;
      stable_o <= 1'b0;
      rise_o   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_o <= 1'b0;
      if (sync_s == stable_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_o <= sync_s;
        rise_o   <= sync_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the three player buttons and hands one command per frame to the
// player state machine over a valid/ready handshake.
module input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int OVERRUN_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 frame_i,
  input  logic                 btn_left_raw_i,
  input  logic                 btn_right_raw_i,
  input  logic                 btn_shoot_raw_i,
  output logic                 btn_left_o,
  output logic                 btn_right_o,
  output logic                 btn_shoot_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OVERRUN_W-1:0] overrun_o
);

  logic stable_left, stable_right, stable_shoot;
  logic rise_left, rise_right, rise_shoot;
  logic unused_bits;

  player_cmd_t          cmd_q;
  player_cmd_t          fresh_cmd;
  logic                 valid_q;
  logic                 shoot_pend_q;
  logic [OVERRUN_W-1:0] overrun_q;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .raw_i    (btn_left_raw_i),
    .stable_o (stable_left),
    .rise_o   (rise_left)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .raw_i    (btn_right_raw_i),
    .stable_o (stable_right),
    .rise_o   (rise_right)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_shoot (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .raw_i    (btn_shoot_raw_i),
    .stable_o (stable_shoot),
    .rise_o   (rise_shoot)
  );

  assign unused_bits = ^{rise_left, rise_right, stable_shoot};

  // A shoot edge arriving on the capture cycle goes straight into this command.
  always_comb begin
    fresh_cmd = resolve_cmd(stable_left, stable_right, shoot_pend_q | rise_shoot);
  end

  // An unconsumed command is overwritten on capture, but its shot is ORed in
  // so a press is never lost to a slow consumer.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cmd_q        <= '0;
      valid_q      <= 1'b0;
      shoot_pend_q <= 1'b0;
      overrun_q    <= '0;
    end else if (frame_i) begin
      valid_q      <= 1'b1;
      shoot_pend_q <= 1'b0;
      cmd_q.left   <= fresh_cmd.left;
      cmd_q.right  <= fresh_cmd.right;
      if (valid_q && !ready_i) begin
        cmd_q.shoot <= cmd_q.shoot | fresh_cmd.shoot;
        if (overrun_q != '1) begin
          overrun_q <= overrun_q + OVERRUN_W'(1);
        end
      end else begin
        cmd_q.shoot <= fresh_cmd.shoot;
      end
    end else begin
      if (rise_shoot) begin
        shoot_pend_q <= 1'b1;
      end
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign btn_left_o  = cmd_q.left;
  assign btn_right_o = cmd_q.right;
  assign btn_shoot_o = cmd_q.shoot;
  assign valid_o     = valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios plus randomized button/frame/ready traffic, all checked
// every cycle against a run-length based reference model.
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int OW   = 8;
  localparam int OMAX = (1 << OW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          frame_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          btn_left_raw_i = 1'b0;
  logic          btn_right_raw_i = 1'b0;
  logic          btn_shoot_raw_i = 1'b0;
  logic          btn_left_o, btn_right_o, btn_shoot_o, valid_o;
  logic [OW-1:0] overrun_o;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  bit       m_valid, m_l, m_r, m_s, m_pend;
  int       m_over;
  bit [1:0] dl[3];
  bit       st[3];
  bit       st_prev[3];
  bit       s_last[3];
  int       rl[3];

  always #5 clk_i = ~clk_i;

  input_conditioner #(.DEBOUNCE_CYCLES(DEB), .OVERRUN_W(OW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .frame_i         (frame_i),
    .btn_left_raw_i  (btn_left_raw_i),
    .btn_right_raw_i (btn_right_raw_i),
    .btn_shoot_raw_i (btn_shoot_raw_i),
    .btn_left_o      (btn_left_o),
    .btn_right_o     (btn_right_o),
    .btn_shoot_o     (btn_shoot_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .overrun_o       (overrun_o)
  );

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_output();
    check_value("valid_o", 32'(valid_o), 32'(m_valid));
    check_value("btn_left_o", 32'(btn_left_o), 32'(m_l));
    check_value("btn_right_o", 32'(btn_right_o), 32'(m_r));
    check_value("btn_shoot_o", 32'(btn_shoot_o), 32'(m_s));
    check_value("overrun_o", 32'(overrun_o), 32'(m_over));
  endtask

  // Stable flips once the synchronised level has held a new value for DEB edges.
  task automatic model_edge();
    bit raw[3];
    bit lr, rr, rise, fs, s;
    raw[0] = btn_left_raw_i;
    raw[1] = btn_right_raw_i;
    raw[2] = btn_shoot_raw_i;
    if (!reset_i) begin
      m_valid = 0; m_l = 0; m_r = 0; m_s = 0; m_pend = 0; m_over = 0;
      for (int b = 0; b < 3; b++) begin
        dl[b] = 2'b00; st[b] = 0; st_prev[b] = 0; s_last[b] = 0; rl[b] = 0;
      end
    end else begin
      lr   = st[0] && !st[1];
      rr   = st[1] && !st[0];
      rise = st[2] && !st_prev[2];
      fs   = m_pend || rise;
      if (frame_i) begin
        if (m_valid && !ready_i) begin
          m_s = m_s || fs;
          if (m_over < OMAX) m_over++;
        end else begin
          m_s = fs;
        end
        m_l = lr; m_r = rr; m_valid = 1; m_pend = 0;
      end else begin
        if (rise) m_pend = 1;
        if (m_valid && ready_i) m_valid = 0;
      end
      for (int b = 0; b < 3; b++) begin
        s = dl[b][1];
        dl[b] = {dl[b][0], raw[b]};
        if (s == s_last[b]) rl[b]++;
        else rl[b] = 1;
        s_last[b] = s;
        st_prev[b] = st[b];
        if (s != st[b] && rl[b] >= DEB) st[b] = s;
      end
    end
  endtask

  task automatic apply_stimulus(input bit rst_n, input bit frame, input bit ready,
                                input bit l, input bit r, input bit s);
    reset_i         = rst_n;
    frame_i         = frame;
    ready_i         = ready;
    btn_left_raw_i  = l;
    btn_right_raw_i = r;
    btn_shoot_raw_i = s;
    model_edge();
    @(negedge clk_i);
    check_output();
  endtask

  initial begin
    int hold[3];
    bit lvl[3];

    // Reset
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_value("rst_valid", 32'(valid_o), 32'd0);
    check_value("rst_left", 32'(btn_left_o), 32'd0);
    check_value("rst_shoot", 32'(btn_shoot_o), 32'd0);
    check_value("rst_overrun", 32'(overrun_o), 32'd0);

    // Debounce latency: stable-left flips on the 6th edge
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0);
    check_value("lat_edge6_valid", 32'(valid_o), 32'd1);
    check_value("lat_edge6_left", 32'(btn_left_o), 32'd0);
    apply_stimulus(1, 1, 1, 1, 0, 0);
    check_value("lat_valid", 32'(valid_o), 32'd1);
    check_value("lat_left", 32'(btn_left_o), 32'd1);
    check_value("lat_right", 32'(btn_right_o), 32'd0);
    check_value("lat_shoot", 32'(btn_shoot_o), 32'd0);
    for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 1, 0, 0, 0);

    // Glitch rejection
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, 0, 0, 0);
    apply_stimulus(1, 1, 1, 0, 0, 0);
    check_value("glitch_valid", 32'(valid_o), 32'd1);
    check_value("glitch_shoot", 32'(btn_shoot_o), 32'd0);
    apply_stimulus(1, 0, 1, 0, 0, 0);

    // One shot per press across three frames
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(1, (i == 15 || i == 31 || i == 47), 1, 0, 0, 1);
      if (i == 15) check_value("single_shot_first", 32'(btn_shoot_o), 32'd1);
      if (i == 31 || i == 47) check_value("single_shot_later", 32'(btn_shoot_o), 32'd0);
    end
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, 0, 0, 0);

    // Left/right conflict
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, 1, 1, 0);
    apply_stimulus(1, 1, 1, 1, 1, 0);
    check_value("conflict_valid", 32'(valid_o), 32'd1);
    check_value("conflict_left", 32'(btn_left_o), 32'd0);
    check_value("conflict_right", 32'(btn_right_o), 32'd0);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 1, 0, 0, 0);

    // Overrun keeps a pending shot
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 1, 0, 1);
    apply_stimulus(1, 1, 0, 1, 0, 1);
    check_value("ovr_f1_shoot", 32'(btn_shoot_o), 32'd1);
    check_value("ovr_f1_overrun", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0);
    check_value("ovr_f2_valid", 32'(valid_o), 32'd1);
    check_value("ovr_f2_shoot", 32'(btn_shoot_o), 32'd1);
    check_value("ovr_f2_left", 32'(btn_left_o), 32'd1);
    check_value("ovr_f2_overrun", 32'(overrun_o), 32'd1);

    // Overrun counter saturation
    for (int i = 0; i < 260; i++) apply_stimulus(1, 1, 0, 1, 0, 0);
    check_value("ovr_saturate", 32'(overrun_o), 32'(OMAX));

    // Reset mid-debounce
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 0, 0, 0);
    check_value("prerst_valid", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    check_value("midrst_valid", 32'(valid_o), 32'd0);
    check_value("midrst_left", 32'(btn_left_o), 32'd0);
    check_value("midrst_shoot", 32'(btn_shoot_o), 32'd0);
    check_value("midrst_overrun", 32'(overrun_o), 32'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1, 0, 0);
    check_value("postrst_edge6_left", 32'(btn_left_o), 32'd0);
    apply_stimulus(1, 1, 1, 1, 0, 0);
    check_value("postrst_edge7_left", 32'(btn_left_o), 32'd1);
    check_value("postrst_overrun", 32'(overrun_o), 32'd0);

    // Randomized traffic
    for (int b = 0; b < 3; b++) begin
      hold[b] = 0;
      lvl[b]  = 0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = bit'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 9);
        end
        hold[b]--;
      end
      apply_stimulus(($urandom_range(0, 999) != 0), ($urandom_range(0, 5) == 0),
                     bit'($urandom_range(0, 1)), lvl[0], lvl[1], lvl[2]);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
